// File: rtl/bit_serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package bit_serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 8;

  // Width of the bit counter; a 1-bit operand still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sc2_block.sv
// Single-bit full-adder cell.
module sc2_block (
  input  logic a_in,
  input  logic b_in,
  input  logic c_in,
  output logic s_out,
  output logic c_out
);

  assign s_out = a_in ^ b_in ^ c_in;
  assign c_out = (a_in & b_in) | (a_in & c_in) | (b_in & c_in);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one operand bit per cycle through a single full-adder cell.
// Optional overflow output enabled by defining BIT_SERIAL_ADDER_OVF_EN.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef BIT_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             s, c;
  logic [WIDTH:0]   res_cat;
  logic [WIDTH-1:0] res_shift;

  sc2_block u_fa (
    .a_in  (a_q[0]),
    .b_in  (b_q[0]),
    .c_in  (carry_q),
    .s_out (s),
    .c_out (c)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
  assign res_cat   = {s, res_q};
  assign res_shift = res_cat[WIDTH:1];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = res_shift;
        carry_d = c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LastCnt) begin
          sum_d   = res_shift;
          cout_d  = c;
`ifdef BIT_SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB on this last step.
          ovf_d   = carry_q ^ c;
`endif
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign ready = (state_q == StIdle);
  assign done  = (state_q == StDone);
  assign sum   = sum_q;
  assign cout  = cout_q;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule
